// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: write-back source and load-kind encodings,
// plus the MEM/WB stage record used by the write-back stage.
package mips_defs;

    localparam logic [1:0] WSEL_ALU  = 2'd0;
    localparam logic [1:0] WSEL_MEM  = 2'd1;
    localparam logic [1:0] WSEL_PC8  = 2'd2;
    localparam logic [1:0] WSEL_HILO = 2'd3;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [1:0]  wsel;
        logic [2:0]  ld_type;
        logic [31:0] alu_res;
        logic [31:0] dm_rdata;
        logic [31:0] hilo;
    } wb_bundle_t;

    // Empty stage contents used both by reset and by a pipeline flush.
    function automatic wb_bundle_t wb_bubble(input logic [31:0] pc_reset);
        wb_bundle_t b;
        b          = '0;
        b.pc       = pc_reset;
        return b;
    endfunction

endpackage

// File: rtl/load_ext.sv
// Load-data extractor: picks the byte/halfword addressed by the low address
// bits out of an aligned memory word and sign- or zero-extends it.
module load_ext
    import mips_defs::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  ld_type,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        byte_sel = rdata[7:0];
        case (off)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
    end

    // Halfword loads are aligned upstream, so only off[1] matters.
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        value = rdata;
        case (ld_type)
            LD_B:    value = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   value = {24'h000000, byte_sel};
            LD_H:    value = {{16{half_sel[15]}}, half_sel};
            LD_HU:   value = {16'h0000, half_sel};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back datapath: drives the GRF write
// port, the forwarding qualifier and a retired-instruction counter.
module wb_stage
    import mips_defs::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             m_valid,
    input  logic [31:0]      m_pc,
    input  logic             m_we,
    input  logic [4:0]       m_waddr,
    input  logic [1:0]       m_wsel,
    input  logic [2:0]       m_ld_type,
    input  logic [31:0]      m_alu_res,
    input  logic [31:0]      m_dm_rdata,
    input  logic [31:0]      m_hilo,
    output logic             grf_we,
    output logic [4:0]       grf_waddr,
    output logic [31:0]      grf_wdata,
    output logic [31:0]      grf_pc,
    output logic             fwd_valid,
    output logic [CNT_W-1:0] retired
);

    wb_bundle_t       stage;
    wb_bundle_t       m_bundle;
    logic [CNT_W-1:0] retired_q;
    logic [31:0]      load_value;

    always_comb begin
        m_bundle          = '0;
        m_bundle.valid    = m_valid;
        m_bundle.pc       = m_pc;
        m_bundle.we       = m_we;
        m_bundle.waddr    = m_waddr;
        m_bundle.wsel     = m_wsel;
        m_bundle.ld_type  = m_ld_type;
        m_bundle.alu_res  = m_alu_res;
        m_bundle.dm_rdata = m_dm_rdata;
        m_bundle.hilo     = m_hilo;
    end

    // Flush loads a bubble but leaves the retire count alone; a flushed
    // capture is never counted.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            stage     <= wb_bubble(PC_RESET);
            retired_q <= '0;
        end else if (flush) begin
            stage     <= wb_bubble(PC_RESET);
        end else if (en) begin
            stage     <= m_bundle;
            if (m_valid)
                retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    load_ext u_load_ext (
        .rdata   (stage.dm_rdata),
        .off     (stage.alu_res[1:0]),
        .ld_type (stage.ld_type),
        .value   (load_value)
    );

    always_comb begin
        grf_wdata = stage.alu_res;
        case (stage.wsel)
            WSEL_MEM:  grf_wdata = load_value;
            WSEL_PC8:  grf_wdata = stage.pc + 32'd8;
            WSEL_HILO: grf_wdata = stage.hilo;
            default:   grf_wdata = stage.alu_res;
        endcase
    end

    assign grf_we    = stage.valid && stage.we && (stage.waddr != 5'd0);
    assign grf_waddr = stage.waddr;
    assign grf_pc    = stage.pc;
    assign fwd_valid = grf_we && (grf_waddr != 5'd0);
    assign retired   = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// compared against a behavioural write-back model.
module tb_wb_stage;
    import mips_defs::*;

    logic        clk = 1'b0;
    logic        reset, en, flush;
    logic        m_valid, m_we;
    logic [31:0] m_pc, m_alu_res, m_dm_rdata, m_hilo;
    logic [4:0]  m_waddr;
    logic [1:0]  m_wsel;
    logic [2:0]  m_ld_type;
    logic        grf_we, fwd_valid;
    logic [4:0]  grf_waddr;
    logic [31:0] grf_wdata, grf_pc, retired;

    int checks = 0;
    int errors = 0;

    // Reference model: what the write-back stage currently holds.
    logic        mv, mwe;
    logic [31:0] mpc, malu, mrd, mhilo, mret;
    logic [4:0]  mwaddr;
    logic [1:0]  mwsel;
    logic [2:0]  mld;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_pc       (m_pc),
        .m_we       (m_we),
        .m_waddr    (m_waddr),
        .m_wsel     (m_wsel),
        .m_ld_type  (m_ld_type),
        .m_alu_res  (m_alu_res),
        .m_dm_rdata (m_dm_rdata),
        .m_hilo     (m_hilo),
        .grf_we     (grf_we),
        .grf_waddr  (grf_waddr),
        .grf_wdata  (grf_wdata),
        .grf_pc     (grf_pc),
        .fwd_valid  (fwd_valid),
        .retired    (retired)
    );

    task automatic model_bubble();
        mv = 0; mwe = 0; mwaddr = 0; mwsel = 0; mld = 0;
        malu = 0; mrd = 0; mhilo = 0; mpc = 32'h0000_3000;
    endtask

    // One clock: inputs were set after a falling edge; model follows the
    // rising edge, outputs are sampled on the next falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            model_bubble();
            mret = 0;
        end else if (flush) begin
            model_bubble();
        end else if (en) begin
            mv = m_valid; mwe = m_we; mwaddr = m_waddr; mwsel = m_wsel; mld = m_ld_type;
            malu = m_alu_res; mrd = m_dm_rdata; mhilo = m_hilo; mpc = m_pc;
            if (m_valid) mret = mret + 1;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input int off, input logic [2:0] ld);
        int unsigned b, h;
        b = (rd >> (8 * off)) & 32'hFF;
        h = (rd >> (16 * (off / 2))) & 32'hFFFF;
        case (ld)
            3'd1:    return (b >= 128) ? b - 256 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata();
        case (mwsel)
            2'd0:    return malu;
            2'd1:    return ref_load(mrd, int'(malu % 4), mld);
            2'd2:    return mpc + 32'd8;
            default: return mhilo;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic we, input logic [4:0] wa,
                         input logic [1:0] ws, input logic [2:0] ld, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [31:0] hl);
        m_valid = v; m_pc = pc; m_we = we; m_waddr = wa; m_wsel = ws;
        m_ld_type = ld; m_alu_res = alu; m_dm_rdata = rd; m_hilo = hl;
    endtask

    task automatic test_reset();
        reset = 1; en = 1; flush = 0;
        drive(1, 32'h1111_0000, 1, 5'd9, WSEL_ALU, LD_W, 32'hDEAD_BEEF, 32'h0, 32'h0);
        tick(); tick();
        reset = 0; en = 0;
        checks += 4;
        if (grf_we !== 1'b0)          begin errors++; $display("FAIL reset_we: got %b want 0", grf_we); end
        if (grf_pc !== 32'h3000)      begin errors++; $display("FAIL reset_pc: got %h want 00003000", grf_pc); end
        if (retired !== 32'd0)        begin errors++; $display("FAIL reset_retired: got %0d want 0", retired); end
        if (fwd_valid !== 1'b0)       begin errors++; $display("FAIL reset_fwd: got %b want 0", fwd_valid); end
    endtask

    task automatic test_alu();
        en = 1;
        drive(1, 32'h3000, 1, 5'd5, WSEL_ALU, LD_W, 32'h1234, 32'h0, 32'h0);
        tick();
        checks += 5;
        if (grf_we !== 1'b1)          begin errors++; $display("FAIL alu_we: got %b want 1", grf_we); end
        if (grf_waddr !== 5'd5)       begin errors++; $display("FAIL alu_waddr: got %0d want 5", grf_waddr); end
        if (grf_wdata !== 32'h1234)   begin errors++; $display("FAIL alu_wdata: got %h want 00001234", grf_wdata); end
        if (retired !== 32'd1)        begin errors++; $display("FAIL alu_retired: got %0d want 1", retired); end
        if (fwd_valid !== 1'b1)       begin errors++; $display("FAIL alu_fwd: got %b want 1", fwd_valid); end
    endtask

    task automatic test_loads();
        logic [2:0]  lds  [4] = '{LD_B, LD_B, LD_HU, LD_H};
        logic [31:0] alus [4] = '{32'h0000_1003, 32'h0000_1001, 32'h0000_1002, 32'h0000_1002};
        logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_007F, 32'h0000_80FF, 32'hFFFF_80FF};
        en = 1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h3008 + 4 * i, 1, 5'd8, WSEL_MEM, lds[i], alus[i], 32'h80FF_7F01, 32'h0);
            tick();
            checks++;
            if (grf_wdata !== exps[i]) begin
                errors++; $display("FAIL load_%0d: got %h want %h", i, grf_wdata, exps[i]);
            end
        end
        checks++;
        if (retired !== 32'd5) begin errors++; $display("FAIL load_retired: got %0d want 5", retired); end
    endtask

    task automatic test_jal();
        en = 1;
        drive(1, 32'h3004, 1, 5'd31, WSEL_PC8, LD_W, 32'h0, 32'h0, 32'h0);
        tick();
        checks += 2;
        if (grf_wdata !== 32'h300C) begin errors++; $display("FAIL jal_wdata: got %h want 0000300c", grf_wdata); end
        if (grf_pc !== 32'h3004)    begin errors++; $display("FAIL jal_pc: got %h want 00003004", grf_pc); end
        drive(1, 32'hFFFF_FFFC, 1, 5'd31, WSEL_PC8, LD_W, 32'h0, 32'h0, 32'h0);
        tick();
        checks++;
        if (grf_wdata !== 32'h4)    begin errors++; $display("FAIL jal_wrap: got %h want 00000004", grf_wdata); end
    endtask

    task automatic test_zero_and_flush();
        en = 1;
        drive(1, 32'h4000, 1, 5'd0, WSEL_HILO, LD_W, 32'h0, 32'h0, 32'h5555_AAAA);
        tick();
        checks += 3;
        if (grf_we !== 1'b0)    begin errors++; $display("FAIL zero_we: got %b want 0", grf_we); end
        if (fwd_valid !== 1'b0) begin errors++; $display("FAIL zero_fwd: got %b want 0", fwd_valid); end
        if (retired !== 32'd8)  begin errors++; $display("FAIL zero_retired: got %0d want 8", retired); end
        flush = 1;
        drive(1, 32'h4004, 1, 5'd3, WSEL_ALU, LD_W, 32'h77, 32'h0, 32'h0);
        tick();
        flush = 0;
        checks += 3;
        if (grf_we !== 1'b0)       begin errors++; $display("FAIL flush_we: got %b want 0", grf_we); end
        if (grf_pc !== 32'h3000)   begin errors++; $display("FAIL flush_pc: got %h want 00003000", grf_pc); end
        if (retired !== 32'd8)     begin errors++; $display("FAIL flush_retired: got %0d want 8", retired); end
    endtask

    task automatic test_hold_then_reset();
        en = 1;
        drive(1, 32'h5000, 1, 5'd7, WSEL_ALU, LD_W, 32'hCAFE_0001, 32'h0, 32'h0);
        tick();
        en = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
                  $urandom, $urandom, $urandom);
            tick();
            checks += 5;
            if (grf_we !== 1'b1)           begin errors++; $display("FAIL hold_we_%0d: got %b want 1", i, grf_we); end
            if (grf_waddr !== 5'd7)        begin errors++; $display("FAIL hold_waddr_%0d: got %0d want 7", i, grf_waddr); end
            if (grf_wdata !== 32'hCAFE_0001) begin errors++; $display("FAIL hold_wdata_%0d: got %h want cafe0001", i, grf_wdata); end
            if (grf_pc !== 32'h5000)       begin errors++; $display("FAIL hold_pc_%0d: got %h want 00005000", i, grf_pc); end
            if (retired !== 32'd9)         begin errors++; $display("FAIL hold_retired_%0d: got %0d want 9", i, retired); end
        end
        reset = 1;
        tick();
        reset = 0;
        checks += 5;
        if (grf_we !== 1'b0)      begin errors++; $display("FAIL hreset_we: got %b want 0", grf_we); end
        if (grf_waddr !== 5'd0)   begin errors++; $display("FAIL hreset_waddr: got %0d want 0", grf_waddr); end
        if (grf_wdata !== 32'h0)  begin errors++; $display("FAIL hreset_wdata: got %h want 0", grf_wdata); end
        if (grf_pc !== 32'h3000)  begin errors++; $display("FAIL hreset_pc: got %h want 00003000", grf_pc); end
        if (retired !== 32'd0)    begin errors++; $display("FAIL hreset_retired: got %0d want 0", retired); end
    endtask

    task automatic test_random();
        logic exp_we;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) < 3);
            flush = ($urandom_range(0, 99) < 10);
            en    = ($urandom_range(0, 99) < 75);
            drive(1'($urandom_range(0, 9) < 8), $urandom, 1'($urandom),
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                  2'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
            tick();
            exp_we = mv && mwe && (mwaddr != 5'd0);
            checks += 6;
            if (grf_we !== exp_we)        begin errors++; $display("FAIL rand_we @%0d: got %b want %b", i, grf_we, exp_we); end
            if (fwd_valid !== exp_we)     begin errors++; $display("FAIL rand_fwd @%0d: got %b want %b", i, fwd_valid, exp_we); end
            if (grf_waddr !== mwaddr)     begin errors++; $display("FAIL rand_waddr @%0d: got %0d want %0d", i, grf_waddr, mwaddr); end
            if (grf_wdata !== ref_wdata()) begin errors++; $display("FAIL rand_wdata @%0d: got %h want %h", i, grf_wdata, ref_wdata()); end
            if (grf_pc !== mpc)           begin errors++; $display("FAIL rand_pc @%0d: got %h want %h", i, grf_pc, mpc); end
            if (retired !== mret)         begin errors++; $display("FAIL rand_retired @%0d: got %0d want %0d", i, retired, mret); end
        end
        reset = 0; flush = 0; en = 0;
    endtask

    initial begin
        reset = 1; en = 0; flush = 0;
        drive(0, 32'h0, 0, 5'd0, WSEL_ALU, LD_W, 32'h0, 32'h0, 32'h0);
        model_bubble();
        mret = 0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_loads();
        test_jal();
        test_zero_and_flush();
        test_hold_then_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
